// File: rtl/interrupt_controller.sv
// Interrupt controller: IE/IF registers, IME flag, fixed-priority dispatch and restart-vector supply.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchroniser on each i_Irq line ahead of edge detection.
module interrupt_controller #(
  parameter int         NUM_IRQ       = 5,
  parameter logic [7:0] VECTOR_BASE   = 8'h40,
  parameter int         VECTOR_STRIDE = 8
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Enable,
  input  logic [NUM_IRQ-1:0] i_Irq,
  input  logic               i_Write_IE,
  input  logic               i_Write_IF,
  input  logic [7:0]         i_Data,
  output logic [7:0]         o_IE,
  output logic [7:0]         o_IF,
  input  logic               i_Boundary,
  input  logic               i_EI,
  input  logic               i_DI,
  input  logic               i_RETI,
  output logic               o_IME,
  output logic               o_Irq_Req,
  input  logic               i_Irq_Ack,
  input  logic               i_Vector_Req,
  output logic [7:0]         o_Vector,
  output logic               o_Vector_Valid,
  output logic               o_Wake
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQUEST, ST_ACTIVE} state_e;

  state_e             state_q, state_d;
  logic [7:0]         ie_q, ie_d;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic               ime_q, ime_d;
  logic               ei_pending_q, ei_pending_d;
  logic [7:0]         vector_q, vector_d;
  logic               vector_valid_q, vector_valid_d;
  logic [NUM_IRQ-1:0] hist_q;

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] sel_mask;
  logic [NUM_IRQ-1:0] clr_mask;
  logic               sel_found;
  logic [7:0]         sel_vector;
  logic               dispatch_vec;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else if (i_Enable) begin
      sync1_q <= i_Irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = i_Irq;
`endif

  assign rise    = irq_s & ~hist_q;
  assign pending = ie_q[NUM_IRQ-1:0] & if_q;

  // Lowest set bit wins: scan downward so the last hit is the highest priority.
  always_comb begin
    sel_found  = 1'b0;
    sel_mask   = '0;
    sel_vector = 8'h00;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_found  = 1'b1;
        sel_mask   = '0;
        sel_mask[i] = 1'b1;
        sel_vector = VECTOR_BASE + 8'(i * VECTOR_STRIDE);
      end
    end
  end

  assign dispatch_vec = (state_q == ST_ACTIVE) && i_Vector_Req;
  assign clr_mask     = (dispatch_vec && sel_found) ? sel_mask : '0;

  // NOTE: every _d signal gets its default first so no path through this block infers a latch.
  always_comb begin
    state_d        = state_q;
    ie_d           = i_Write_IE ? i_Data : ie_q;
    if_d           = rise | (i_Write_IF ? i_Data[NUM_IRQ-1:0] : (if_q & ~clr_mask));
    ime_d          = ime_q;
    ei_pending_d   = ei_pending_q;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE:    if (i_Boundary && ime_q && (|pending)) state_d = ST_REQUEST;
      ST_REQUEST: if (i_Irq_Ack) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (i_Vector_Req) begin
          state_d        = ST_IDLE;
          vector_d       = sel_found ? sel_vector : 8'h00;
          vector_valid_d = 1'b1;
        end
      end
      default:    state_d = ST_IDLE;
    endcase

    if (i_DI || ((state_q == ST_REQUEST) && i_Irq_Ack)) begin
      ime_d        = 1'b0;
      ei_pending_d = 1'b0;
    end else begin
      if (i_Boundary && ei_pending_q) begin
        ime_d        = 1'b1;
        ei_pending_d = 1'b0;
      end
      if (i_RETI) ime_d = 1'b1;
      if (i_EI)   ei_pending_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q        <= ST_IDLE;
      ie_q           <= '0;
      if_q           <= '0;
      ime_q          <= 1'b0;
      ei_pending_q   <= 1'b0;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      hist_q         <= '0;
    end else if (i_Enable) begin
      state_q        <= state_d;
      ie_q           <= ie_d;
      if_q           <= if_d;
      ime_q          <= ime_d;
      ei_pending_q   <= ei_pending_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      hist_q         <= irq_s;
    end
  end

  always_comb begin
    o_IF = 8'hFF;
    o_IF[NUM_IRQ-1:0] = if_q;
  end

  assign o_IE           = ie_q;
  assign o_IME          = ime_q;
  assign o_Irq_Req      = (state_q == ST_REQUEST);
  assign o_Vector       = vector_q;
  assign o_Vector_Valid = vector_valid_q;
  assign o_Wake         = |pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_interrupt_controller;

  localparam int         N  = 5;
  localparam logic [7:0] VB = 8'h40;
  localparam int         VS = 8;
`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam int PH_IDLE = 0, PH_REQ = 1, PH_ACTIVE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b1;
  logic [N-1:0] irq = '0;
  logic         wie = 1'b0, wif = 1'b0;
  logic [7:0]   data = 8'h00;
  logic         bnd = 1'b0, ei = 1'b0, di = 1'b0, reti = 1'b0;
  logic         ack = 1'b0, vreq = 1'b0;

  logic [7:0]   o_ie, o_if, o_vector;
  logic         o_ime, o_req, o_valid, o_wake;

  int n_tests = 0;
  int n_fail  = 0;

  interrupt_controller #(.NUM_IRQ(N), .VECTOR_BASE(VB), .VECTOR_STRIDE(VS)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Irq(irq),
    .i_Write_IE(wie), .i_Write_IF(wif), .i_Data(data),
    .o_IE(o_ie), .o_IF(o_if),
    .i_Boundary(bnd), .i_EI(ei), .i_DI(di), .i_RETI(reti),
    .o_IME(o_ime), .o_Irq_Req(o_req), .i_Irq_Ack(ack), .i_Vector_Req(vreq),
    .o_Vector(o_vector), .o_Vector_Valid(o_valid), .o_Wake(o_wake)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]   m_ie;
  logic [N-1:0] m_if, m_hist, m_s1, m_s2;
  logic         m_ime, m_eip, m_valid;
  logic [7:0]   m_vec;
  int           m_phase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ie = 8'h00; m_if = '0; m_hist = '0; m_s1 = '0; m_s2 = '0;
    m_ime = 1'b0; m_eip = 1'b0; m_valid = 1'b0; m_vec = 8'h00; m_phase = PH_IDLE;
  endtask

  task automatic model_step();
    logic [N-1:0] samp, rise, pend, nif;
    int k, clr_bit, nphase;
    logic nime, neip, nvalid;
    logic [7:0] nvec;
    if (!en) return;
`ifdef IRQ_SYNC_EN
    samp = m_s2;
`else
    samp = irq;
`endif
    rise    = samp & ~m_hist;
    pend    = m_ie[N-1:0] & m_if;
    k       = lowest(pend);
    clr_bit = -1;
    nphase  = m_phase;
    nvalid  = 1'b0;
    nvec    = m_vec;
    if (m_phase == PH_IDLE && bnd && m_ime && pend != 0) nphase = PH_REQ;
    else if (m_phase == PH_REQ && ack) nphase = PH_ACTIVE;
    else if (m_phase == PH_ACTIVE && vreq) begin
      nphase = PH_IDLE;
      nvalid = 1'b1;
      if (k >= 0) begin
        nvec    = 8'((VB + k * VS) % 256);
        clr_bit = k;
      end else nvec = 8'h00;
    end
    for (int i = 0; i < N; i++) begin
      if (rise[i])          nif[i] = 1'b1;
      else if (wif)         nif[i] = data[i];
      else if (i == clr_bit) nif[i] = 1'b0;
      else                  nif[i] = m_if[i];
    end
    nime = m_ime; neip = m_eip;
    if (di || (m_phase == PH_REQ && ack)) begin
      nime = 1'b0; neip = 1'b0;
    end else begin
      if (bnd && m_eip) begin nime = 1'b1; neip = 1'b0; end
      if (reti) nime = 1'b1;
      if (ei)   neip = 1'b1;
    end
    if (wie) m_ie = data;
    m_if = nif; m_ime = nime; m_eip = neip; m_phase = nphase;
    m_valid = nvalid; m_vec = nvec;
    m_s2 = m_s1; m_s1 = irq; m_hist = samp;
  endtask

  task automatic compare_all();
    logic [7:0] exp_if;
    exp_if = 8'hFF;
    exp_if[N-1:0] = m_if;
    check("IE", o_ie, m_ie);
    check("IF", o_if, exp_if);
    check("IME", o_ime, m_ime);
    check("IRQ_REQ", o_req, m_phase == PH_REQ);
    check("VECTOR", o_vector, m_vec);
    check("VALID", o_valid, m_valid);
    check("WAKE", o_wake, |(m_ie[N-1:0] & m_if));
  endtask

  task automatic quiet();
    en = 1'b1; wie = 1'b0; wif = 1'b0; bnd = 1'b0;
    ei = 1'b0; di = 1'b0; reti = 1'b0; ack = 1'b0; vreq = 1'b0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    quiet();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("RST_REQ", o_req, 1'b0);
    check("RST_IF", o_if, 8'hE0);
    check("RST_VEC", o_vector, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    quiet();
    model_reset();
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    check("T1_IE", o_ie, 8'h00);
    check("T1_IME", o_ime, 1'b0);

    // Basic dispatch: sources 2 and 4 pending, source 2 wins
    wie = 1'b1; data = 8'h1F; cycle();
    reti = 1'b1; cycle();
    irq = 5'b10100; cycle();
    idle(SYNC_LAT);
    check("T2_IF_SET", o_if, 8'hF4);
    bnd = 1'b1; cycle();
    check("T2_REQ", o_req, 1'b1);
    ack = 1'b1; cycle();
    check("T2_REQ_DROP", o_req, 1'b0);
    check("T2_IME", o_ime, 1'b0);
    vreq = 1'b1; cycle();
    check("T2_VEC", o_vector, 8'h50);
    check("T2_VALID", o_valid, 1'b1);
    check("T2_IF", o_if, 8'hF0);
    cycle();
    check("T2_VALID_PULSE", o_valid, 1'b0);
    check("T2_VEC_HOLD", o_vector, 8'h50);

    // EI delay: no dispatch at the EI's own boundary
    irq = '0; wif = 1'b1; data = 8'h00; cycle();
    irq = 5'b00001; cycle();
    idle(SYNC_LAT);
    ei = 1'b1; cycle();
    bnd = 1'b1; cycle();
    check("T3_IME", o_ime, 1'b1);
    check("T3_NOREQ", o_req, 1'b0);
    cycle();
    check("T3_NOREQ2", o_req, 1'b0);
    bnd = 1'b1; cycle();
    check("T3_REQ", o_req, 1'b1);
    ack = 1'b1; cycle();
    vreq = 1'b1; cycle();
    check("T3_VEC", o_vector, 8'h40);
    check("T3_IF", o_if, 8'hE0);

    // IE withdrawn while ACTIVE: null vector, IF untouched
    irq = '0; cycle();
    idle(SYNC_LAT);
    irq = 5'b00001; cycle();
    idle(SYNC_LAT);
    reti = 1'b1; cycle();
    bnd = 1'b1; cycle();
    check("T4_REQ", o_req, 1'b1);
    ack = 1'b1; cycle();
    wie = 1'b1; data = 8'h00; cycle();
    vreq = 1'b1; cycle();
    check("T4_VEC", o_vector, 8'h00);
    check("T4_VALID", o_valid, 1'b1);
    check("T4_IF", o_if, 8'hE1);

    // Hardware set beats software write; DI beats EI
    wie = 1'b1; data = 8'h1F; irq = '0; cycle();
    idle(SYNC_LAT);
    irq = 5'b00010;
    idle(SYNC_LAT);
    wif = 1'b1; data = 8'h00; cycle();
    check("T5_IF1", o_if[1], 1'b1);
    reti = 1'b1; cycle();
    check("T5_IME_ON", o_ime, 1'b1);
    ei = 1'b1; di = 1'b1; cycle();
    check("T5_EI_DI", o_ime, 1'b0);
    bnd = 1'b1; cycle();
    check("T5_NO_EIP", o_ime, 1'b0);

    // Wake without IME, then reset during REQUEST
    wie = 1'b1; data = 8'h08; cycle();
    wif = 1'b1; data = 8'h08; cycle();
    check("T6_WAKE", o_wake, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bnd = 1'b1; cycle();
      check("T6_NOREQ", o_req, 1'b0);
    end
    reti = 1'b1; cycle();
    bnd = 1'b1; cycle();
    check("T6_REQ", o_req, 1'b1);
    do_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        en   = ($urandom_range(0, 9) != 0);
        wie  = ($urandom_range(0, 19) == 0);
        wif  = ($urandom_range(0, 19) == 0);
        data = 8'($urandom);
        bnd  = ($urandom_range(0, 3) == 0);
        ei   = ($urandom_range(0, 9) == 0);
        di   = ($urandom_range(0, 24) == 0);
        reti = ($urandom_range(0, 11) == 0);
        ack  = ($urandom_range(0, 2) == 0);
        vreq = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 4) == 0) irq = N'($urandom);
        model_step();
        @(posedge clk);
        #1;
        compare_all();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
